// File: rtl/booth_mul_iter_pkg.sv
// Shared types and constants for the iterative radix-16 multiplier.
package booth_mul_iter_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam int unsigned N_FULL = 16;
  localparam int unsigned N_WORD = 8;
  localparam int unsigned ACC_W  = 128;

  // Select the architectural result field from the 128-bit accumulator.
  function automatic logic [63:0] fmt_result(logic [ACC_W-1:0] acc, op_e op, logic word);
    if (word) return {{32{acc[31]}}, acc[31:0]};
    if (op == OP_MUL) return acc[63:0];
    return acc[ACC_W-1:64];
  endfunction

endpackage

// File: rtl/booth_mul_iter_if.sv
// Operand/result handshake bundle for booth_mul_iter.
interface booth_mul_iter_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_in_bits_src1;
  logic [63:0] io_in_bits_src2;
  logic [1:0]  io_in_bits_op;
  logic        io_in_bits_word;
  logic        io_flush;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_bits_result;

  modport master (
    output io_in_valid, io_in_bits_src1, io_in_bits_src2, io_in_bits_op,
           io_in_bits_word, io_flush, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_result
  );

  modport slave (
    input  io_in_valid, io_in_bits_src1, io_in_bits_src2, io_in_bits_op,
           io_in_bits_word, io_flush, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_result
  );
endinterface

// File: rtl/BoothEncoder4.sv
// Radix-16 digit encoder: the 5-bit window is a two's-complement digit in [-16,15];
// negative digits are expressed as -(weight+1) so weight stays a plain 4-bit magnitude.
module BoothEncoder4 (
  input  logic [4:0] window,
  output logic       neg,
  output logic [3:0] weight
);
  assign neg    = window[4];
  assign weight = window[4] ? ~window[3:0] : window[3:0];
endmodule

// File: rtl/booth_mul_iter.sv
// Iterative 64x64 multiplier retiring one radix-16 digit of B per BUSY cycle
// into a 128-bit accumulator; supports MUL/MULH/MULHSU/MULHU and MULW.
module booth_mul_iter
  import booth_mul_iter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  booth_mul_iter_if.slave io
);

  state_e           state_q;
  logic [63:0]      a_q, b_q;
  op_e              op_q;
  logic             word_q;
  logic [ACC_W-1:0] acc_q;
  logic [3:0]       cnt_q;
  logic             in_ready_q, out_valid_q;
  logic [63:0]      result_q;

  logic [ACC_W-1:0] a_ext, prod, term, acc_nxt;
  logic [5:0]       shamt;
  logic [3:0]       last_cnt, weight;
  logic [4:0]       window;
  logic             b_signed, last_iter, neg;

  always_comb begin
    if (word_q)                                     a_ext = {{(ACC_W-32){a_q[31]}}, a_q[31:0]};
    else if (op_q == OP_MULH || op_q == OP_MULHSU)  a_ext = {{(ACC_W-64){a_q[63]}}, a_q};
    else                                            a_ext = {{(ACC_W-64){1'b0}}, a_q};
  end

  assign shamt     = {cnt_q, 2'b00};
  assign last_cnt  = word_q ? 4'(N_WORD - 1) : 4'(N_FULL - 1);
  assign last_iter = (cnt_q == last_cnt);
  assign b_signed  = !word_q && (op_q == OP_MULH);
  // Only the top digit carries B's sign; lower digits are unsigned nibbles.
  assign window    = {last_iter && b_signed && b_q[63], b_q[shamt +: 4]};

  BoothEncoder4 u_enc (
    .window (window),
    .neg    (neg),
    .weight (weight)
  );

  assign prod    = a_ext * {{(ACC_W-4){1'b0}}, weight};
  assign term    = neg ? (~prod + ACC_W'(1) - a_ext) : prod;
  assign acc_nxt = acc_q + (term << shamt);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_MUL;
      word_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (io.io_flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.io_in_valid) begin
            a_q        <= io.io_in_bits_src1;
            b_q        <= io.io_in_bits_src2;
            op_q       <= op_e'(io.io_in_bits_op);
            word_q     <= io.io_in_bits_word;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 4'd1;
          if (last_iter) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= fmt_result(acc_nxt, op_q, word_q);
          end
        end
        S_DONE: begin
          if (io.io_out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.io_in_ready        = in_ready_q;
  assign io.io_out_valid       = out_valid_q;
  assign io.io_out_bits_result = result_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter: directed vectors, flush/reset/backpressure
// sequences, and randomized operations against a 128-bit arithmetic reference.
module tb_booth_mul_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  booth_mul_iter_if io ();

  booth_mul_iter dut (
    .clock (clk),
    .reset (rst),
    .io    (io)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        word;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] ref_mul(logic [63:0] a, logic [63:0] b, logic [1:0] op, logic word);
    logic [127:0] ae, be, p;
    if (word) begin
      ae = {{96{a[31]}}, a[31:0]};
      be = {{96{b[31]}}, b[31:0]};
      p  = ae * be;
      return {{32{p[31]}}, p[31:0]};
    end
    ae = (op == 2'd1 || op == 2'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    be = (op == 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ae * be;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic word);
    int n;
    io.io_in_bits_src1 = a;
    io.io_in_bits_src2 = b;
    io.io_in_bits_op   = op;
    io.io_in_bits_word = word;
    io.io_in_valid     = 1'b1;
    n = 0;
    while (!io.io_in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_before_hs", 64'(io.io_in_ready), 64'd1);
    tick();
    io.io_in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [63:0] res, output bit zero_ok);
    lat     = 1;
    zero_ok = 1'b1;
    while (!io.io_out_valid && lat < 40) begin
      if (io.io_out_bits_result != 64'd0) zero_ok = 1'b0;
      tick();
      lat++;
    end
    res = io.io_out_bits_result;
  endtask

  task automatic accept();
    io.io_out_ready = 1'b1;
    tick();
    io.io_out_ready = 1'b0;
  endtask

  task automatic quiet(input int cycles, output bit q);
    q = 1'b1;
    repeat (cycles) begin
      if (io.io_out_valid) q = 1'b0;
      tick();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          n;
    logic [63:0] res, a, b;
    logic [1:0]  op;
    logic        word;
    bit          zok, q;

    vecs[0]  = '{64'd3, 64'd5, 2'd0, 1'b0, 64'h0000_0000_0000_000F, 17};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 64'h0, 17};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 17};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 17};
    vecs[4]  = '{64'h7FFF_FFFF, 64'd2, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 9};
    vecs[5]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 17};
    vecs[6]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 1'b0, 64'h4000_0000_0000_0000, 17};
    vecs[7]  = '{64'h1234_5678_FFFF_FFFD, 64'hABCD_EF00_0000_0005, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 9};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'd3, 1'b0, 64'h1, 17};
    vecs[9]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 64'h3FFF_FFFF_FFFF_FFFF, 17};
    vecs[10] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 2'd3, 1'b1, 64'h1, 9};

    io.io_in_valid     = 1'b0;
    io.io_in_bits_src1 = '0;
    io.io_in_bits_src2 = '0;
    io.io_in_bits_op   = '0;
    io.io_in_bits_word = 1'b0;
    io.io_flush        = 1'b0;
    io.io_out_ready    = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 64'(io.io_in_ready), 64'd1);
    chk("reset_out_valid", 64'(io.io_out_valid), 64'd0);
    chk("reset_result", io.io_out_bits_result, 64'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].word);
      wait_out(lat, res, zok);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_zero_while_busy", i), 64'(zok), 64'd1);
      accept();
      chk($sformatf("vec%0d_idle_after_accept", i), 64'(io.io_in_ready), 64'd1);
    end

    // Backpressure: result must hold in DONE while out_ready is low.
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'd3, 1'b0);
    wait_out(lat, res, zok);
    repeat (5) begin
      chk("hold_valid", 64'(io.io_out_valid), 64'd1);
      chk("hold_result", io.io_out_bits_result, 64'd1);
      chk("hold_in_ready", 64'(io.io_in_ready), 64'd0);
      tick();
    end
    accept();
    chk("hold_release_in_ready", 64'(io.io_in_ready), 64'd1);
    chk("hold_release_valid", 64'(io.io_out_valid), 64'd0);

    // Flush during BUSY iteration 7.
    start_op(64'h1234, 64'h5678, 2'd0, 1'b0);
    repeat (7) tick();
    io.io_flush = 1'b1;
    tick();
    io.io_flush = 1'b0;
    chk("flush_in_ready", 64'(io.io_in_ready), 64'd1);
    chk("flush_out_valid", 64'(io.io_out_valid), 64'd0);
    quiet(25, q);
    chk("flush_quiet", 64'(q), 64'd1);
    start_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0);
    wait_out(lat, res, zok);
    chk("after_flush_result", res, 64'hFFFF_FFFF_FFFF_FFF9);
    accept();

    // Flush beats a same-cycle input handshake in IDLE.
    io.io_in_bits_src1 = 64'd9;
    io.io_in_bits_src2 = 64'd9;
    io.io_in_bits_op   = 2'd0;
    io.io_in_bits_word = 1'b0;
    io.io_in_valid     = 1'b1;
    io.io_flush        = 1'b1;
    tick();
    io.io_in_valid = 1'b0;
    io.io_flush    = 1'b0;
    chk("flush_vs_in_ready", 64'(io.io_in_ready), 64'd1);
    quiet(20, q);
    chk("flush_vs_in_quiet", 64'(q), 64'd1);

    // Flush beats a same-cycle output handshake in DONE.
    start_op(64'd6, 64'd7, 2'd0, 1'b0);
    wait_out(lat, res, zok);
    io.io_flush     = 1'b1;
    io.io_out_ready = 1'b1;
    tick();
    io.io_flush     = 1'b0;
    io.io_out_ready = 1'b0;
    chk("flush_done_valid", 64'(io.io_out_valid), 64'd0);
    chk("flush_done_result", io.io_out_bits_result, 64'd0);
    chk("flush_done_in_ready", 64'(io.io_in_ready), 64'd1);

    for (int unsigned i = 0; i < 2000; i++) begin
      a    = rnd64();
      b    = rnd64();
      op   = 2'($urandom_range(0, 3));
      word = ($urandom_range(0, 3) == 0);
      n    = word ? 8 : 16;
      if (i == 700) begin
        start_op(a, b, op, word);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midbusy_reset_in_ready", 64'(io.io_in_ready), 64'd1);
        chk("midbusy_reset_valid", 64'(io.io_out_valid), 64'd0);
        quiet(n + 4, q);
        chk("midbusy_reset_quiet", 64'(q), 64'd1);
      end else if ($urandom_range(0, 15) == 0) begin
        start_op(a, b, op, word);
        repeat ($urandom_range(0, n - 1)) tick();
        io.io_flush = 1'b1;
        tick();
        io.io_flush = 1'b0;
        quiet(n + 4, q);
        chk("rand_flush_quiet", 64'(q), 64'd1);
      end else begin
        start_op(a, b, op, word);
        wait_out(lat, res, zok);
        chk($sformatf("rand%0d_op%0d_w%0d_result", i, op, word), res, ref_mul(a, b, op, word));
        chk("rand_latency", 64'(lat), 64'(n + 1));
        chk("rand_zero_while_busy", 64'(zok), 64'd1);
        repeat ($urandom_range(0, 2)) tick();
        accept();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
